mining_sequencer: RTL
=====================

# mining_sequencer

Top-level controller for the SHA-256 mining datapath. It drives the shared 3-bit `state` code and address/nonce lines into the preprocessing block and the compression block. It iterates a nonce range, one full hash per nonce, and stops on the first nonce whose hash meets the difficulty flag or when the range is exhausted. It is the only driver of `state`, `indirizzo`, `NONCE`, `nonce_flag` and `reset_fsm` in the miner.

## Interface
- `MSG_AW`, 7: width of the message word address (`indirizzo`).
- `MAX_CHUNKS`, 8: watchdog limit on chunks per hash (used only with the watchdog macro).
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high. Returns the block to IDLE.
- `start` in 1: one-cycle pulse that begins a run. Ignored unless in IDLE.
- `abort` in 1: ends a run. Sampled in any non-IDLE state.
- `msg_words` in `MSG_AW`: number of 32-bit message words to load. Legal range 1..127; 0 is treated as 1.
- `nonce_start` in 32: first nonce tried.
- `nonce_end` in 32: last nonce tried, inclusive.
- `pre_fine` in 1: `fine` from preprocessing. High means the last chunk has been issued.
- `fine_mining` in 1: difficulty-met flag from the compression block.
- `state` out 3: datapath state code.
- `indirizzo` out `MSG_AW`: message word address during LOAD.
- `NONCE` out 32: current nonce.
- `nonce_flag` out 1: constant 1 (nonce overwrites the low 32 bits).
- `reset_fsm` out 1: datapath soft reset.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: hash met difficulty. Valid with `done`, held until the next `start`.
- `golden_nonce` out 32: winning nonce. Valid when `found`=1.

## Operation
FSM states, with the `state` code driven in each:
- IDLE (000): `start` → RESTART. Latch `nonce_start` into `NONCE`, clear `found`.
- RESTART (000): `reset_fsm`=1 for exactly 1 cycle, `indirizzo`=0 → LOAD.
- LOAD (001): the external source presents the word for `indirizzo`. `indirizzo` counts up each cycle. After `msg_words` cycles → PAD. `indirizzo` then holds the last word address (`msg_words`-1).
- PAD (010): 1 cycle → FETCH.
- FETCH (011): 1 cycle; the datapath registers one chunk. Increment `chunk_cnt` → PREP.
- PREP (100) → ROUND (101) → UPD (110): 1 cycle each.
- In UPD: `pre_fine`=1 → FINAL; otherwise → FETCH.
- FINAL (111): 1 cycle → CHECK.
- CHECK (000): sample `fine_mining`.
  - If 1: `found`=1, `golden_nonce`=`NONCE`, `done`, → IDLE.
  - Else if `NONCE`==`nonce_end`: `found`=0, `done`, → IDLE.
  - Else: `NONCE`=`NONCE`+1 mod 2^32 (0xFFFFFFFF wraps to 0) → RESTART.

Boundary and priority rules:
- `nonce_start`==`nonce_end`: exactly one hash is computed.
- `nonce_start`>`nonce_end`: the range wraps through 0.
- `abort` in any non-IDLE state: next state IDLE, `done`=1, `found`=0, `reset_fsm`=1 for that cycle. `abort` wins over a simultaneous CHECK decision.
- `start` while busy: ignored.
- `reset` wins over everything.

## Timing
- Reset values: `state`=000, `indirizzo`=0, `NONCE`=0, `nonce_flag`=1, `reset_fsm`=0, `busy`=0, `done`=0, `found`=0, `golden_nonce`=0.
- All outputs are registered.
- Per-nonce cycle count, with W = `msg_words` and C = chunks in the hash: 1 (RESTART) + W (LOAD) + 1 (PAD) + 4C + 1 (FINAL) + 1 (CHECK) = W + 4C + 4.
- `done` asserts in the cycle after CHECK (or after `abort`). `busy` falls in that same cycle.
- `fine_mining` is sampled in CHECK, one cycle after FINAL, to match its registered output.

## Configuration
- `MINER_WATCHDOG_EN` defined: `chunk_cnt` (4-bit, cleared in RESTART) is compared in UPD. If `chunk_cnt`==`MAX_CHUNKS` and `pre_fine`=0, the run ends as an abort and the extra output `wdog_err` (1-bit, reset 0, cleared on `start`) is set.
- `MINER_WATCHDOG_EN` undefined: no `wdog_err` port, and chunk looping is unbounded.

## Test plan
- W=16, 2 chunks, `nonce_start`=`nonce_end`=5, `fine_mining` modelled 1 → `done` at cycle 28 after the start acceptance, `found`=1, `golden_nonce`=5.
- Range 0..3, `fine_mining` high only for nonce 2 → exactly 3 RESTART pulses, `golden_nonce`=2.
- `nonce_start`=0xFFFFFFFE, `nonce_end`=1, never found → `NONCE` sequence FFFFFFFE, FFFFFFFF, 0, 1, then `done`, `found`=0.
- `abort` in the ROUND state of the second nonce → next cycle `done`=1, `reset_fsm`=1, `found`=0; IDLE after that.
- `start` pulsed mid-run → no effect; sync `reset` in the LOAD state → all outputs at their reset values the next cycle.
- With `MINER_WATCHDOG_EN`, `MAX_CHUNKS`=2 and `pre_fine` held 0 → `wdog_err`=1 and `done` after the second UPD.

Source files
------------

// File: rtl/mining_sequencer_if.sv
// mining_sequencer_if
// Bundles the control, range and datapath handshake signals of the mining
// sequencer so the controller and its environment connect through one port.
//   master : the sequencer (drives state/indirizzo/NONCE/status outputs)
//   slave  : the environment (drives start/abort/range/datapath flags)
// Optional: MINER_WATCHDOG_EN adds the wdog_err status line.
interface mining_sequencer_if #(
  parameter int MSG_AW = 7
);
  logic              start;
  logic              abort;
  logic [MSG_AW-1:0] msg_words;
  logic [31:0]       nonce_start;
  logic [31:0]       nonce_end;
  logic              pre_fine;
  logic              fine_mining;
  logic [2:0]        state;
  logic [MSG_AW-1:0] indirizzo;
  logic [31:0]       NONCE;
  logic              nonce_flag;
  logic              reset_fsm;
  logic              busy;
  logic              done;
  logic              found;
  logic [31:0]       golden_nonce;
`ifdef MINER_WATCHDOG_EN
  logic              wdog_err;
`endif

  modport master (
    input  start, abort, msg_words, nonce_start, nonce_end, pre_fine, fine_mining,
    output state, indirizzo, NONCE, nonce_flag, reset_fsm, busy, done, found,
           golden_nonce
`ifdef MINER_WATCHDOG_EN
    , output wdog_err
`endif
  );

  modport slave (
    output start, abort, msg_words, nonce_start, nonce_end, pre_fine, fine_mining,
    input  state, indirizzo, NONCE, nonce_flag, reset_fsm, busy, done, found,
           golden_nonce
`ifdef MINER_WATCHDOG_EN
    , input wdog_err
`endif
  );
endinterface

// File: rtl/mining_sequencer.sv
// mining_sequencer
// Top-level controller of the SHA-256 mining datapath. Walks a nonce range,
// running one full hash per nonce (restart, message load, pad, chunk loop,
// final, check), and stops on the first nonce that meets difficulty or when
// the range is exhausted. Sole driver of state/indirizzo/NONCE/nonce_flag/
// reset_fsm.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; returns to IDLE
//   bus    : mining_sequencer_if.master (start/abort/range inputs, datapath
//            flags pre_fine/fine_mining, state code, address, nonce, status)
// Optional feature: define MINER_WATCHDOG_EN to bound the chunk loop at
// MAX_CHUNKS chunks per hash; overrun ends the run as an abort and raises
// bus.wdog_err.
module mining_sequencer #(
  parameter int MSG_AW = 7
`ifdef MINER_WATCHDOG_EN
  ,
  parameter int MAX_CHUNKS = 8
`endif
) (
  input  logic               clock,
  input  logic               reset,
  mining_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESTART,
    S_LOAD,
    S_PAD,
    S_FETCH,
    S_PREP,
    S_ROUND,
    S_UPD,
    S_FINAL,
    S_CHECK
  } fsm_t;

  // Datapath state codes; IDLE, RESTART and CHECK share 000.
  localparam logic [2:0] CODE_IDLE    = 3'b000;
  localparam logic [2:0] CODE_RESTART = 3'b000;
  localparam logic [2:0] CODE_LOAD    = 3'b001;
  localparam logic [2:0] CODE_PAD     = 3'b010;
  localparam logic [2:0] CODE_FETCH   = 3'b011;
  localparam logic [2:0] CODE_PREP    = 3'b100;
  localparam logic [2:0] CODE_ROUND   = 3'b101;
  localparam logic [2:0] CODE_UPD     = 3'b110;
  localparam logic [2:0] CODE_FINAL   = 3'b111;
  localparam logic [2:0] CODE_CHECK   = 3'b000;

  fsm_t              fsm_q;
  logic [2:0]        state_q;
  logic [MSG_AW-1:0] indirizzo_q;
  logic [31:0]       nonce_q;
  logic              nonce_flag_q;
  logic              reset_fsm_q;
  logic              busy_q;
  logic              done_q;
  logic              found_q;
  logic [31:0]       golden_q;
`ifdef MINER_WATCHDOG_EN
  logic [3:0]        chunk_cnt_q;
  logic              wdog_err_q;
`endif

  // Address of the last message word; a word count of 0 loads one word.
  logic [MSG_AW-1:0] last_addr;

  // Last LOAD address derived from the requested word count.
  always_comb begin
    last_addr = '0;
    if (bus.msg_words == '0) begin
      last_addr = '0;
    end else begin
      last_addr = bus.msg_words - MSG_AW'(1);
    end
  end

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      state_q      <= CODE_IDLE;
      indirizzo_q  <= '0;
      nonce_q      <= 32'd0;
      nonce_flag_q <= 1'b1;
      reset_fsm_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      golden_q     <= 32'd0;
`ifdef MINER_WATCHDOG_EN
      chunk_cnt_q  <= 4'd0;
      wdog_err_q   <= 1'b0;
`endif
    end else begin
      // Pulses default low; nonce always overwrites the low 32 bits.
      done_q       <= 1'b0;
      reset_fsm_q  <= 1'b0;
      nonce_flag_q <= 1'b1;
      if ((fsm_q != S_IDLE) && bus.abort) begin
        // Abort outranks any decision taken in the current state.
        fsm_q       <= S_IDLE;
        state_q     <= CODE_IDLE;
        done_q      <= 1'b1;
        found_q     <= 1'b0;
        reset_fsm_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (fsm_q)
          S_IDLE: begin
            if (bus.start) begin
              fsm_q       <= S_RESTART;
              state_q     <= CODE_RESTART;
              nonce_q     <= bus.nonce_start;
              found_q     <= 1'b0;
              busy_q      <= 1'b1;
              reset_fsm_q <= 1'b1;
              indirizzo_q <= '0;
`ifdef MINER_WATCHDOG_EN
              wdog_err_q  <= 1'b0;
`endif
            end
          end
          S_RESTART: begin
`ifdef MINER_WATCHDOG_EN
            chunk_cnt_q <= 4'd0;
`endif
            fsm_q   <= S_LOAD;
            state_q <= CODE_LOAD;
          end
          S_LOAD: begin
            // Address holds at the last word so PAD onward still sees it.
            if (indirizzo_q == last_addr) begin
              fsm_q   <= S_PAD;
              state_q <= CODE_PAD;
            end else begin
              indirizzo_q <= indirizzo_q + MSG_AW'(1);
            end
          end
          S_PAD: begin
            fsm_q   <= S_FETCH;
            state_q <= CODE_FETCH;
          end
          S_FETCH: begin
`ifdef MINER_WATCHDOG_EN
            chunk_cnt_q <= chunk_cnt_q + 4'd1;
`endif
            fsm_q   <= S_PREP;
            state_q <= CODE_PREP;
          end
          S_PREP: begin
            fsm_q   <= S_ROUND;
            state_q <= CODE_ROUND;
          end
          S_ROUND: begin
            fsm_q   <= S_UPD;
            state_q <= CODE_UPD;
          end
          S_UPD: begin
            if (bus.pre_fine) begin
              fsm_q   <= S_FINAL;
              state_q <= CODE_FINAL;
            end
`ifdef MINER_WATCHDOG_EN
            else if (chunk_cnt_q == 4'(MAX_CHUNKS)) begin
              // Runaway chunk loop: finish exactly like an abort.
              fsm_q       <= S_IDLE;
              state_q     <= CODE_IDLE;
              done_q      <= 1'b1;
              found_q     <= 1'b0;
              reset_fsm_q <= 1'b1;
              busy_q      <= 1'b0;
              wdog_err_q  <= 1'b1;
            end
`endif
            else begin
              fsm_q   <= S_FETCH;
              state_q <= CODE_FETCH;
            end
          end
          S_FINAL: begin
            // fine_mining is registered downstream, so judge it next cycle.
            fsm_q   <= S_CHECK;
            state_q <= CODE_CHECK;
          end
          S_CHECK: begin
            if (bus.fine_mining) begin
              fsm_q    <= S_IDLE;
              state_q  <= CODE_IDLE;
              found_q  <= 1'b1;
              golden_q <= nonce_q;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else if (nonce_q == bus.nonce_end) begin
              fsm_q   <= S_IDLE;
              state_q <= CODE_IDLE;
              found_q <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // Wraps through zero when the range crosses 0xFFFFFFFF.
              fsm_q       <= S_RESTART;
              state_q     <= CODE_RESTART;
              nonce_q     <= nonce_q + 32'd1;
              reset_fsm_q <= 1'b1;
              indirizzo_q <= '0;
            end
          end
          default: begin
            fsm_q   <= S_IDLE;
            state_q <= CODE_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.indirizzo    = indirizzo_q;
  assign bus.NONCE        = nonce_q;
  assign bus.nonce_flag   = nonce_flag_q;
  assign bus.reset_fsm    = reset_fsm_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.found        = found_q;
  assign bus.golden_nonce = golden_q;
`ifdef MINER_WATCHDOG_EN
  assign bus.wdog_err     = wdog_err_q;
`endif

endmodule
